// File: rtl/fece_mult_seq.sv
// Wide unsigned multiplier sequencer: walks digit pairs through one shared external 3x3 FECE multiplier.
// Optional: MULT_SEQ_ZERO_SKIP_EN short-circuits jobs with a zero operand straight to a zero product.
module fece_mult_seq #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*DIGITS-1:0]   a,
  input  logic [3*DIGITS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6*DIGITS-1:0]   product,
  output logic                  busy,
  output logic [2:0]            mul_x,
  output logic [2:0]            mul_y,
  input  logic [5:0]            mul_p
);
  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready high
  // RUN   | one digit pair per cycle through the shared multiplier
  // DONE  | product presented, waiting for out_ready

  localparam int OW = 3 * DIGITS;
  localparam int PW = 6 * DIGITS;
  localparam logic [2:0] LAST = 3'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   a_reg, b_reg;
  logic [2:0]      i_cnt, j_cnt;
  logic [PW-1:0]   acc, acc_sum, term;
  logic [5:0]      shx, shy;
  logic [6:0]      shp;
  logic            accept, last, skip;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  logic skip_reg;
  assign skip = skip_reg;
`else
  assign skip = 1'b0;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign last      = (i_cnt == LAST) && (j_cnt == LAST);
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  always_comb begin
    shx     = 6'(i_cnt) * 6'd3;
    shy     = 6'(j_cnt) * 6'd3;
    shp     = (7'(i_cnt) + 7'(j_cnt)) * 7'd3;
    mul_x   = 3'd0;
    mul_y   = 3'd0;
    if (state == RUN && !skip) begin
      mul_x = 3'(a_reg >> shx);
      mul_y = 3'(b_reg >> shy);
    end
    term    = PW'(mul_p) << shp;
    acc_sum = acc + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (skip || last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      i_cnt   <= 3'd0;
      j_cnt   <= 3'd0;
      product <= '0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
      skip_reg <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      acc   <= '0;
      i_cnt <= 3'd0;
      j_cnt <= 3'd0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
      skip_reg <= (a == '0) || (b == '0);
`endif
    end else if (state == RUN) begin
      if (skip) begin
        product <= '0;
      end else begin
        acc <= acc_sum;
        if (last) product <= acc_sum;
        // j is the inner digit index, i advances when j wraps
        if (j_cnt == LAST) begin
          j_cnt <= 3'd0;
          i_cnt <= (i_cnt == LAST) ? 3'd0 : i_cnt + 3'd1;
        end else begin
          j_cnt <= j_cnt + 3'd1;
        end
      end
    end
  end
endmodule
